// File: rtl/pipes_pkg.sv
// Shared types for pipeline-stage plumbing: skid-buffer state and stage payloads.
package pipes_pkg;

  // Occupancy of a two-entry skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Example stage payload; instances pack this into a flat WIDTH-bit vector.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } decode_data_t;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;
  assign count    = r_count;

  // Count up on inc, hold once every bit is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for valid/ready pipelines with flush and stall counter.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | nothing held; in_ready = 1, out_valid = 0
// BUSY  | main holds the head entry; in_ready = 1, out_valid = 1
// FULL  | main holds the head, skid holds the next; in_ready = 0
//
// in_ready is decoded from the state register only, so neither out_ready nor
// in_valid has a combinational path to it; upstream timing stays isolated.
module pipe_skid_reg
  import pipes_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_t      r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  skid_state_t      w_state_nxt;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_stall;

  assign in_ready   = (r_state != FULL);
  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Back-pressure is counted even in a flush cycle; flush never clears the count.
  assign w_stall    = out_valid & ~out_ready;

  // Next state and next register contents; flush wins over every handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = BUSY;
          end
        end
        BUSY: begin
          case ({w_in_fire, w_out_fire})
            2'b11: w_main_nxt = in_data;
            2'b10: begin
              w_skid_nxt  = in_data;
              w_state_nxt = FULL;
            end
            2'b01: w_state_nxt = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = BUSY;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  // State and payload registers; reset overrides flush and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg against a queue-based occupancy model.
module tb_pipe_skid_reg;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: entries held, in arrival order, plus the stall count.
  logic [WIDTH-1:0] mq[$];
  int               mcnt;
  bit               mzero;
  int               ndeliv;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check against the model, then advance the model.
  task automatic step(input logic rst, input logic fl, input logic v,
                      input logic [WIDTH-1:0] d, input logic rdy, input bit tog);
    bit ir, ov, infire, ofire;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = v; in_data = d; out_ready = rdy;
    #1;
    ir = (mq.size() < 2);
    ov = (mq.size() > 0);
    check("in_ready", in_ready, ir);
    check("out_valid", out_valid, ov);
    if (ov) check("out_data", out_data, mq[0]);
    else if (mzero) check("out_data_zero", out_data, 0);
    check("stall_cnt", stall_cnt, mcnt);
    if (tog) begin
      out_ready = ~rdy; in_valid = ~v;
      #1;
      check("in_ready_comb", in_ready, ir);
      out_ready = rdy; in_valid = v;
      #1;
    end
    @(posedge clk);
    infire = v && ir;
    ofire  = ov && rdy;
    if (rst) begin
      mq.delete(); mcnt = 0; mzero = 1;
    end else begin
      if (ov && !rdy && mcnt < CNT_MAX) mcnt++;
      if (ofire) ndeliv++;
      if (fl) begin
        mq.delete(); mzero = 1;
      end else begin
        if (ofire) void'(mq.pop_front());
        if (infire) begin mq.push_back(d); mzero = 0; end
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mcnt = 0; mzero = 1; ndeliv = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // Streaming: data i shows up one cycle after it is offered.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b1, WIDTH'(i), 1'b1, 1'b0);
      #2;
      check("stream_data", out_data, i);
      check("stream_ready", in_ready, 1);
    end
    check("stream_stall", stall_cnt, 0);

    // Back-pressure: A, B fill the buffer, C is refused while full.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    #2;
    check("bp_in_ready", in_ready, 0);
    check("bp_out_data", out_data, 8'hA1);
    check("bp_stall", stall_cnt, 4);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    #2;
    check("bp_second", out_data, 8'hB2);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    #2;
    check("bp_drained", out_valid, 0);
    check("bp_stall_final", stall_cnt, 4);

    // Flush while full with a concurrent offer of C.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0);
    #2;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_out_data", out_data, 0);
    check("fl_stall", stall_cnt, 2);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Flush together with an out_fire, then immediate refill.
    step(1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Saturation of a 4-bit stall counter.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    check("sat_stall", stall_cnt, 15);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    #2;
    check("sat_after_flush", stall_cnt, 15);

    // Reset while full with an incoming offer.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'h71, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h72, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h73, 1'b1, 1'b0);
    #2;
    check("rm_in_ready", in_ready, 1);
    check("rm_out_valid", out_valid, 0);
    check("rm_out_data", out_data, 0);
    check("rm_stall", stall_cnt, 0);

    // Randomised traffic with rare flushes and resets.
    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(999) == 0), ($urandom_range(99) == 0),
           ($urandom_range(9) < 7), WIDTH'($urandom), ($urandom_range(9) < 6), 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
